// File: rtl/aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// aes_inv_key_sched
// Inverse AES-128 key scheduler for the decryption datapath. The block either
// expands a cipher key forward for NR rounds to reach the last round key, or
// takes the last round key directly. It then walks the schedule backwards and
// presents round keys NR, NR-1, ... 0, one per valid/ready transfer.
//
// Ports
//   iClk        clock, rising edge
//   iRsn        asynchronous active-low reset
//   iStart      start request, sampled only while idle
//   iKeyIsLast  1: iKey is the round-NR key, 0: iKey is the cipher key
//   iKey        key input, w0 = [127:96] ... w3 = [31:0]
//   iClear      synchronous abort, overrides everything but reset
//   iKeyReady   consumer accepts oRoundKey when high with oKeyValid
//   oRoundKey   current round key, same word order as iKey
//   oRoundNum   round index of oRoundKey
//   oKeyValid   oRoundKey / oRoundNum are valid
//   oBusy       high whenever the block is not idle
//   oDone       one-cycle pulse after round key 0 is accepted
// -----------------------------------------------------------------------------
module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         iClk,
    input  logic         iRsn,
    input  logic         iStart,
    input  logic         iKeyIsLast,
    input  logic [127:0] iKey,
    input  logic         iClear,
    input  logic         iKeyReady,
    output logic [127:0] oRoundKey,
    output logic [3:0]   oRoundNum,
    output logic         oKeyValid,
    output logic         oBusy,
    output logic         oDone
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    // Forward AES S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_OUT
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Entry b occupies bits (255-b)*8+7 down to (255-b)*8.
        logic [10:0] top;
        top = {~b, 3'b111};
        return SBOX_FLAT[top -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    sbox_in, t_word;
    logic [3:0]     rcon_idx;
    logic [127:0]   fwd_key, inv_key;

    // Shared S-box word path: the forward step substitutes the old w3, the
    // inverse step substitutes the recovered w3' = w3 ^ w2.
    always_comb begin
        w0       = key_q[127:96];
        w1       = key_q[95:64];
        w2       = key_q[63:32];
        w3       = key_q[31:0];
        sbox_in  = (state_q == S_FWD) ? w3 : (w3 ^ w2);
        rcon_idx = (state_q == S_FWD) ? (cnt_q + 4'd1) : cnt_q;
        t_word   = sub_word({sbox_in[23:0], sbox_in[31:24]}) ^ {rcon(rcon_idx), 24'h0};

        fwd_key[127:96] = w0 ^ t_word;
        fwd_key[95:64]  = w1 ^ fwd_key[127:96];
        fwd_key[63:32]  = w2 ^ fwd_key[95:64];
        fwd_key[31:0]   = w3 ^ fwd_key[63:32];

        inv_key[127:96] = w0 ^ t_word;
        inv_key[95:64]  = w1 ^ w0;
        inv_key[63:32]  = w2 ^ w1;
        inv_key[31:0]   = w3 ^ w2;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    key_d = iKey;
                    if (iKeyIsLast) begin
                        cnt_d   = LAST_RND;
                        state_d = S_OUT;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = S_FWD;
                    end
                end
            end
            S_FWD: begin
                key_d = fwd_key;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == LAST_RND) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (iKeyReady) begin
                    if (cnt_q != 4'd0) begin
                        key_d = inv_key;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort returns to idle; key and counter contents are don't-care.
        if (iClear) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end

        valid_d = (state_d == S_OUT);
        busy_d  = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oRoundKey = key_q;
    assign oRoundNum = cnt_q;
    assign oKeyValid = valid_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_key_sched
// Scoreboard bench for the inverse AES-128 key scheduler. Stimulus pushes the
// expected round-key sequence (FIPS-197 example schedule) into a queue when it
// starts a run; an independent monitor pops an entry at every accepted
// transfer, checks key stability while stalled and checks the oDone pulse.
// -----------------------------------------------------------------------------
module tb_aes_inv_key_sched;

    typedef struct {
        logic [3:0]   num;
        logic [127:0] key;
    } exp_t;

    logic         iClk = 1'b0;
    logic         iRsn;
    logic         iStart;
    logic         iKeyIsLast;
    logic [127:0] iKey;
    logic         iClear;
    logic         iKeyReady;
    logic [127:0] oRoundKey;
    logic [3:0]   oRoundNum;
    logic         oKeyValid;
    logic         oBusy;
    logic         oDone;

    int n_cmp = 0;
    int n_err = 0;

    exp_t exp_q[$];

    // FIPS-197 Appendix A.1 schedule for cipher key 2b7e1516...09cf4f3c.
    logic [127:0] gk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_inv_key_sched #(.NR(10)) dut (
        .iClk       (iClk),
        .iRsn       (iRsn),
        .iStart     (iStart),
        .iKeyIsLast (iKeyIsLast),
        .iKey       (iKey),
        .iClear     (iClear),
        .iKeyReady  (iKeyReady),
        .oRoundKey  (oRoundKey),
        .oRoundNum  (oRoundNum),
        .oKeyValid  (oKeyValid),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_seq();
        for (int r = 10; r >= 0; r--) begin
            exp_q.push_back('{num: 4'(r), key: gk[r]});
        end
    endtask

    // Pulses iStart for one accepted edge; returns just after that edge.
    task automatic start_run(input logic [127:0] key, input logic is_last);
        @(posedge iClk);
        #1;
        iKey       = key;
        iKeyIsLast = is_last;
        iStart     = 1'b1;
        push_seq();
        @(posedge iClk);
        #1;
        iStart = 1'b0;
    endtask

    task automatic check_latency(input string name, input int req);
        int n;
        n = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge iClk);
            if (oKeyValid) begin
                n = i;
                break;
            end
        end
        check(name, 128'(n), 128'(req));
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge iClk);
            if (oDone) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 128'(seen), 128'(1));
    endtask

    task automatic wait_round(input string name, input logic [3:0] num);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge iClk);
            #1;
            if (oKeyValid && oRoundNum == num) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 128'(seen), 128'(1));
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge.
    bit           done_exp = 1'b0;
    bit           stall_valid = 1'b0;
    logic [127:0] stall_key;
    logic [3:0]   stall_num;

    always @(negedge iClk) begin
        if (!iRsn) begin
            done_exp    = 1'b0;
            stall_valid = 1'b0;
        end else begin
            if (oDone || done_exp) begin
                check("done_pulse", 128'(oDone), 128'(done_exp));
            end
            done_exp = 1'b0;
            if (stall_valid) begin
                check("stall_valid", 128'(oKeyValid), 128'(1));
                check("stall_key", oRoundKey, stall_key);
                check("stall_num", 128'(oRoundNum), 128'(stall_num));
            end
            stall_valid = 1'b0;
            if (oKeyValid) begin
                if (iKeyReady) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_key", 128'(oRoundNum), 128'hffff);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("round_num", 128'(oRoundNum), 128'(e.num));
                        check("round_key", oRoundKey, e.key);
                        if (e.num == 4'd0 && !iClear) begin
                            done_exp = 1'b1;
                        end
                    end
                end else begin
                    stall_valid = 1'b1;
                    stall_key   = oRoundKey;
                    stall_num   = oRoundNum;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        iRsn       = 1'b0;
        iStart     = 1'b0;
        iKeyIsLast = 1'b0;
        iKey       = '0;
        iClear     = 1'b0;
        iKeyReady  = 1'b1;

        // Reset values.
        #2;
        check("rst_key", oRoundKey, 128'h0);
        check("rst_num", 128'(oRoundNum), 128'h0);
        check("rst_valid", 128'(oKeyValid), 128'h0);
        check("rst_busy", 128'(oBusy), 128'h0);
        check("rst_done", 128'(oDone), 128'h0);
        repeat (2) @(posedge iClk);
        #1;
        iRsn = 1'b1;

        // Cipher key path: full forward expansion, then 11 keys back-to-back.
        start_run(gk[0], 1'b0);
        check("fwd_busy", 128'(oBusy), 128'(1));
        check_latency("fwd_latency", 11);
        wait_done("fwd_done");

        // Last-key path: first key on the cycle after the start edge.
        start_run(gk[10], 1'b1);
        check_latency("last_latency", 1);
        wait_done("last_done");

        // Backpressure: stall three cycles while round 6 is presented.
        start_run(gk[0], 1'b0);
        wait_round("bp_reach_r6", 4'd6);
        iKeyReady = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        iKeyReady = 1'b1;
        wait_done("bp_done");

        // Abort during the fifth forward cycle.
        start_run(gk[0], 1'b0);
        repeat (4) @(posedge iClk);
        #1;
        iClear = 1'b1;
        @(posedge iClk);
        #1;
        iClear = 1'b0;
        check("clr_busy", 128'(oBusy), 128'(0));
        check("clr_valid", 128'(oKeyValid), 128'(0));
        check("clr_done", 128'(oDone), 128'(0));
        exp_q.delete();

        // Fresh start after abort; iStart during OUT must be ignored.
        start_run(gk[0], 1'b0);
        wait_round("ign_reach_r10", 4'd10);
        iKey       = 128'h00112233445566778899aabbccddeeff;
        iKeyIsLast = 1'b1;
        iStart     = 1'b1;
        repeat (5) @(posedge iClk);
        #1;
        iStart = 1'b0;
        wait_done("ign_done");

        // Reset while round 4 is presented.
        start_run(gk[10], 1'b1);
        wait_round("rst_reach_r4", 4'd4);
        iRsn = 1'b0;
        #1;
        check("mid_rst_key", oRoundKey, 128'h0);
        check("mid_rst_num", 128'(oRoundNum), 128'h0);
        check("mid_rst_valid", 128'(oKeyValid), 128'h0);
        check("mid_rst_busy", 128'(oBusy), 128'h0);
        check("mid_rst_done", 128'(oDone), 128'h0);
        exp_q.delete();
        repeat (2) @(posedge iClk);
        #1;
        iRsn = 1'b1;
        start_run(gk[0], 1'b0);
        wait_done("post_rst_done");

        // iStart held high: second run starts one idle cycle after oDone.
        @(posedge iClk);
        #1;
        iKey       = gk[10];
        iKeyIsLast = 1'b1;
        iStart     = 1'b1;
        push_seq();
        push_seq();
        wait_done("held_done1");
        check("held_idle_busy", 128'(oBusy), 128'(0));
        @(negedge iClk);
        check("held_restart_valid", 128'(oKeyValid), 128'(1));
        check("held_restart_num", 128'(oRoundNum), 128'(10));
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        wait_done("held_done2");

        repeat (3) @(negedge iClk);
        check("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
